// File: rtl/exmem_skid_stage_if.sv
// EX/MEM boundary bundle: EX-side payload with valid/ready and the registered MEM-side copy.
// slave is the stage's view; master is the environment (EX producer + MEM consumer).
interface exmem_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
);
  logic              validE;
  logic              readyE;
  logic              zeroE;
  logic              regwriteE;
  logic              memtoregE;
  logic              memwriteE;
  logic              branchE;
  logic [DATA_W-1:0] aluoutE;
  logic [DATA_W-1:0] writedataE;
  logic [REG_W-1:0]  writeregE;
  logic [ADDR_W-1:0] pcbranchE;

  logic              validM;
  logic              readyM;
  logic              zeroM;
  logic              regwriteM;
  logic              memtoregM;
  logic              memwriteM;
  logic              branchM;
  logic [DATA_W-1:0] aluoutM;
  logic [DATA_W-1:0] writedataM;
  logic [REG_W-1:0]  writeregM;
  logic [ADDR_W-1:0] pcbranchM;
  logic              pcsrcM;

  modport slave (
    input  validE, zeroE, regwriteE, memtoregE, memwriteE, branchE,
    input  aluoutE, writedataE, writeregE, pcbranchE,
    output readyE,
    output validM, zeroM, regwriteM, memtoregM, memwriteM, branchM,
    output aluoutM, writedataM, writeregM, pcbranchM, pcsrcM,
    input  readyM
  );

  modport master (
    output validE, zeroE, regwriteE, memtoregE, memwriteE, branchE,
    output aluoutE, writedataE, writeregE, pcbranchE,
    input  readyE,
    input  validM, zeroM, regwriteM, memtoregM, memwriteM, branchM,
    input  aluoutM, writedataM, writeregM, pcbranchM, pcsrcM,
    output readyM
  );
endinterface

// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline stage with a 2-entry skid buffer, synchronous flush and bubble gating.
// Optional macro EXMEM_PCSRC_EN: when defined, pcsrcM = validM & branchM & zeroM; otherwise 0.
module exmem_skid_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  exmem_skid_stage_if.slave bus
);
  typedef struct packed {
    logic              zero;
    logic              regwrite;
    logic              memtoreg;
    logic              memwrite;
    logic              branch;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] writedata;
    logic [REG_W-1:0]  writereg;
    logic [ADDR_W-1:0] pcbranch;
  } entry_t;

  entry_t in_e;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept;
  logic   drain;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid and payload must hold until then. readyE comes straight from a flop.
  assign bus.readyE = !skid_valid_q;
  assign accept     = bus.validE & bus.readyE;
  assign drain      = main_valid_q & bus.readyM;

  assign in_e = {bus.zeroE, bus.regwriteE, bus.memtoregE, bus.memwriteE, bus.branchE,
                 bus.aluoutE, bus.writedataE, bus.writeregE, bus.pcbranchE};

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = in_e;
      end else if (accept) begin
        main_d       = in_e;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: the incoming entry parks in the skid slot.
      skid_d       = in_e;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.validM     = main_valid_q;
  assign bus.zeroM      = main_q.zero;
  assign bus.regwriteM  = main_valid_q & main_q.regwrite;
  assign bus.memtoregM  = main_valid_q & main_q.memtoreg;
  assign bus.memwriteM  = main_valid_q & main_q.memwrite;
  assign bus.branchM    = main_valid_q & main_q.branch;
  assign bus.aluoutM    = main_q.aluout;
  assign bus.writedataM = main_q.writedata;
  assign bus.writeregM  = main_q.writereg;
  assign bus.pcbranchM  = main_q.pcbranch;

`ifdef EXMEM_PCSRC_EN
  assign bus.pcsrcM = main_valid_q & main_q.branch & main_q.zero;
`else
  assign bus.pcsrcM = 1'b0;
`endif
endmodule

// File: tb/tb_exmem_skid_stage.sv
// Bench for exmem_skid_stage: directed steps then random traffic against a 2-deep FIFO model.
// Honours EXMEM_PCSRC_EN for the expected pcsrcM.
module tb_exmem_skid_stage;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;
  localparam int PW     = 5 + 2 * DATA_W + REG_W + ADDR_W;
`ifdef EXMEM_PCSRC_EN
  localparam bit PCSRC_ON = 1'b1;
`else
  localparam bit PCSRC_ON = 1'b0;
`endif

  logic clk;
  logic reset_n;
  logic flush;
  int   total;
  int   bad;
  logic [PW-1:0] exp_q[$];

  exmem_skid_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

  exmem_skid_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] in_pack();
    return {bus.zeroE, bus.regwriteE, bus.memtoregE, bus.memwriteE, bus.branchE,
            bus.aluoutE, bus.writedataE, bus.writeregE, bus.pcbranchE};
  endfunction

  function automatic logic [PW-1:0] out_pack();
    return {bus.zeroM, bus.regwriteM, bus.memtoregM, bus.memwriteM, bus.branchM,
            bus.aluoutM, bus.writedataM, bus.writeregM, bus.pcbranchM};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: head of the queue is what MEM must see
  task automatic check_outputs();
    logic [PW-1:0] head;
    check("validM", 128'(bus.validM), 128'(exp_q.size() > 0));
    check("readyE", 128'(bus.readyE), 128'(exp_q.size() < 2));
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      check("payload", 128'(out_pack()), 128'(head));
      check("pcsrcM", 128'(bus.pcsrcM), 128'(PCSRC_ON & head[PW-5] & head[PW-1]));
    end else begin
      check("bubble_ctl", 128'({bus.regwriteM, bus.memtoregM, bus.memwriteM, bus.branchM, bus.pcsrcM}),
            128'(5'b0));
    end
  endtask

  task automatic check_reset_state();
    check("rst_validM", 128'(bus.validM), 128'(1'b0));
    check("rst_readyE", 128'(bus.readyE), 128'(1'b1));
    check("rst_outs", 128'(out_pack()), 128'(0));
    check("rst_pcsrc", 128'(bus.pcsrcM), 128'(1'b0));
  endtask

  // driver: one clock; the model steps on the same edge using the held inputs
  task automatic tick();
    bit acc;
    bit drn;
    @(posedge clk);
    acc = bus.validE && (exp_q.size() < 2);
    drn = (exp_q.size() > 0) && bus.readyM;
    if (!reset_n || flush) begin
      exp_q.delete();
    end else begin
      if (drn) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(in_pack());
    end
    #1;
    check_outputs();
  endtask

  task automatic set_in(input logic v, input logic [DATA_W-1:0] alu);
    bus.validE     = v;
    bus.aluoutE    = alu;
    bus.writedataE = ~alu;
    bus.writeregE  = alu[REG_W-1:0];
    bus.pcbranchE  = alu + 32'h100;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b1;
    flush   = 1'b0;
    bus.readyM    = 1'b1;
    bus.zeroE     = 1'b0;
    bus.regwriteE = 1'b0;
    bus.memtoregE = 1'b0;
    bus.memwriteE = 1'b0;
    bus.branchE   = 1'b0;
    set_in(1'b1, 32'h0000_1234);

    // async reset with validE held high
    #2 reset_n = 1'b0;
    #1 check_reset_state();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("first_alu", 128'(bus.aluoutM), 128'(32'h0000_1234));
    check("first_valid", 128'(bus.validM), 128'(1'b1));

    // streaming
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, DATA_W'(i));
      tick();
      check("stream_alu", 128'(bus.aluoutM), 128'(i));
      check("stream_ready", 128'(bus.readyE), 128'(1'b1));
    end
    set_in(1'b0, 32'h0);
    tick();

    // backpressure: A, B fill the stage, C waits
    bus.readyM = 1'b0;
    set_in(1'b1, 32'hA); tick();
    set_in(1'b1, 32'hB); tick();
    check("bp_ready_low", 128'(bus.readyE), 128'(1'b0));
    set_in(1'b1, 32'hC); tick();
    check("bp_hold_a", 128'(bus.aluoutM), 128'(32'hA));
    bus.readyM = 1'b1;
    tick();
    check("bp_out_b", 128'(bus.aluoutM), 128'(32'hB));
    tick();
    check("bp_out_c", 128'(bus.aluoutM), 128'(32'hC));
    set_in(1'b0, 32'h0);
    tick();
    check("bp_empty", 128'(bus.validM), 128'(1'b0));

    // flush with both entries held and C presented
    bus.readyM = 1'b0;
    bus.regwriteE = 1'b1;
    bus.memwriteE = 1'b1;
    set_in(1'b1, 32'hA); tick();
    set_in(1'b1, 32'hB); tick();
    set_in(1'b1, 32'hC);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", 128'(bus.validM), 128'(1'b0));
    check("flush_ctl", 128'({bus.regwriteM, bus.memwriteM}), 128'(2'b00));
    check("flush_ready", 128'(bus.readyE), 128'(1'b1));
    set_in(1'b0, 32'h0);
    bus.readyM = 1'b1;
    tick();
    tick();

    // bubble gating of controls
    set_in(1'b1, 32'h55); tick();
    check("bub_rw_on", 128'({bus.regwriteM, bus.memwriteM}), 128'(2'b11));
    set_in(1'b0, 32'h0); tick();
    check("bub_ctl_off", 128'({bus.validM, bus.regwriteM, bus.memwriteM, bus.branchM}), 128'(4'b0));
    bus.regwriteE = 1'b0;
    bus.memwriteE = 1'b0;

    // branch decision
    bus.branchE = 1'b1;
    bus.zeroE   = 1'b1;
    set_in(1'b1, 32'h77); tick();
    check("pcsrc_taken", 128'(bus.pcsrcM), 128'(PCSRC_ON));
    bus.zeroE = 1'b0;
    tick();
    check("pcsrc_not", 128'(bus.pcsrcM), 128'(1'b0));
    bus.branchE = 1'b0;
    set_in(1'b0, 32'h0); tick();

    // reset mid-operation discards everything
    bus.readyM = 1'b0;
    set_in(1'b1, 32'h99); tick();
    set_in(1'b1, 32'h9A); tick();
    reset_n = 1'b0;
    #1 check_reset_state();
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    set_in(1'b0, 32'h0);
    bus.readyM = 1'b1;
    tick();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      bus.validE     = ($urandom_range(0, 3) != 0);
      bus.readyM     = ($urandom_range(0, 2) != 0);
      flush          = ($urandom_range(0, 29) == 0);
      bus.zeroE      = 1'($urandom);
      bus.regwriteE  = 1'($urandom);
      bus.memtoregE  = 1'($urandom);
      bus.memwriteE  = 1'($urandom);
      bus.branchE    = 1'($urandom);
      bus.aluoutE    = $urandom;
      bus.writedataE = $urandom;
      bus.writeregE  = REG_W'($urandom);
      bus.pcbranchE  = $urandom;
      tick();
    end
    flush = 1'b0;
    bus.validE = 1'b0;
    bus.readyM = 1'b1;
    tick();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exmem_skid_stage.md
Name: exmem_skid_stage

Overview:
Parametrised EX/MEM pipeline stage for the pipelined MIPS core. It is the successor to the plain EX/MEM clocked register and adds configurable widths, valid/ready handshaking and a 2-entry skid buffer, so the memory stage can apply backpressure without a combinational ready path. It also supports a synchronous flush for branch/exception squash, and bubbles present deasserted control bits.

Parameters:
DATA_W, 32, width of aluoutE/writedataE
ADDR_W, 32, width of pcbranchE
REG_W, 5, width of writeregE (register index)

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all held and incoming entries
validE  in  1  EX presents an instruction
readyE  out  1  stage can accept; registered (no comb path from readyM)
zeroE, regwriteE, memtoregE, memwriteE, branchE  in  1 each  EX flags/controls
aluoutE, writedataE  in  DATA_W  EX results
writeregE  in  REG_W  destination register
pcbranchE  in  ADDR_W  branch target
validM  out  1  MEM-side entry valid
readyM  in  1  MEM consumes current entry
zeroM, regwriteM, memtoregM, memwriteM, branchM  out  1 each  registered copies
aluoutM, writedataM  out  DATA_W; writeregM  out  REG_W; pcbranchM  out  ADDR_W
pcsrcM  out  1  branch-taken (see Optional Feature)

Behaviour:
- Storage: main entry (drives all *M outputs) and skid entry, each with a valid bit.
- accept = validE & readyE; drain = validM & readyM.
- readyE = !skid_valid.
- Main update when main empty or drain:
  - load skid if skid valid;
  - else load input if accept;
  - else main becomes empty.
- Skid update: when main is valid, not draining, and accept, the input goes to skid. When main loads from skid, skid empties, unless accept occurs in the same cycle, in which case the input goes to skid.
- Order strictly FIFO. No entry is lost or duplicated. Latency is 1 cycle from accept to validM when empty. Sustained throughput is 1/cycle with readyM=1.
- Bubble: when validM=0, regwriteM, memwriteM, memtoregM, branchM and pcsrcM are forced 0. Data outputs hold their last value, but the bench must not check them.
- flush (priority over everything): next edge clears main_valid and skid_valid. The same-cycle input is not captured even if validE=1. readyE is 1 in the following cycle.
- Simultaneous flush with drain: the drained entry counts as consumed this cycle; nothing remains.
- Async reset (reset_n=0): both valid bits 0; all *M outputs 0; readyE=1 immediately and after release. Reset mid-operation discards all entries.
- No arithmetic; fields are copied bit-exact at parameter widths.

Optional Feature:
EXMEM_PCSRC_EN
- Defined: pcsrcM = validM & branchM & zeroM, combinational from main entry registers.
- Undefined: pcsrcM tied 0; the branch decision is made in the MEM stage logic. The port is always present.

Test Plan:
- Reset: reset_n=0 with validE=1 -> validM=0, all *M=0, readyE=1; after release, the first accept of aluoutE=0x0000_1234 appears on aluoutM next cycle with validM=1.
- Streaming: 4 entries aluoutE=1,2,3,4 with readyM=1 -> aluoutM=1,2,3,4 on consecutive cycles; readyE stays 1.
- Backpressure: readyM=0 while sending A=0xA, B=0xB -> main=A, skid=B, readyE=0 next cycle, validE C=0xC held. readyM=1 -> outputs A,B,C in order, none dropped.
- Flush: main=A, skid=B, validE=1 with C, flush=1 -> next cycle validM=0, regwriteM=memwriteM=0, readyE=1; C never appears.
- Bubble controls: accept regwriteE=1, memwriteE=1, then drain with no new input -> validM=0 and regwriteM=memwriteM=branchM=0.
- EXMEM_PCSRC_EN: branchE=1, zeroE=1 accepted -> pcsrcM=1 with validM=1; zeroE=0 -> pcsrcM=0. Without the macro, pcsrcM=0 always.
